hist_eq_divider: RTL and testbench
==================================

HIST_EQ_DIVIDER -- requirements
Module: hist_eq_divider

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning CDF values per memory word.
REQ-002 SHALL have parameter DATA_W, default 32, meaning width of one CDF lane.
REQ-003 SHALL have parameter ADDR_W, default 16, meaning scratch-memory address width.
REQ-004 SHALL have parameter NUM_WORDS, default 64, meaning words processed per run (LANES*NUM_WORDS bins).
REQ-005 SHALL have parameter Q_W, default 8, meaning output grey-level width; LEVELS = 2^Q_W-1.
REQ-006 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- enable  in  1  run request, level.
- cdf_min  in  DATA_W  minimum non-zero CDF.
- cdf_total  in  DATA_W  total pixel count (CDF of last bin).
- div_sc_mem_rd_addr  out  ADDR_W  read address.
- div_sc_mem_rd_data  in  LANES*DATA_W  read data, valid one cycle after address.
- div_sc_mem_wt_addr  out  ADDR_W  write address.
- div_sc_mem_wt_data  out  LANES*DATA_W  results, lane i at bits [i*DATA_W +: DATA_W], zero-extended from Q_W.
- div_sc_mem_wt_en  out  1  write strobe, one cycle per word.
- div_sc_mem_rd_done  out  1  all words read, held until IDLE.
- div_sc_mem_wt_done  out  1  all words written, held until IDLE.
- busy  out  1  high in any state but IDLE/DONE.

Function
REQ-007 SHALL implement FSM IDLE -> RD_ADDR -> CAPTURE -> DIVIDE -> WRITE -> (RD_ADDR | DONE).
REQ-008 IDLE SHALL go to RD_ADDR when enable=1; word counter cleared to 0.
REQ-009 RD_ADDR SHALL drive div_sc_mem_rd_addr = word counter for one cycle.
REQ-010 CAPTURE SHALL register rd_data, cdf_min, cdf_total; per lane numerator N = (cdf - cdf_min)*LEVELS, divisor D = cdf_total - cdf_min, widths DATA_W+Q_W.
REQ-011 DIVIDE SHALL last exactly Q_W cycles, one restoring-division quotient bit per cycle per lane, MSB first, all lanes in parallel.
REQ-012 WRITE SHALL assert div_sc_mem_wt_en for one cycle with wt_addr = word counter, then increment the counter.
REQ-013 Per-word latency SHALL be Q_W+3 cycles; a run SHALL take NUM_WORDS*(Q_W+3) cycles from leaving IDLE to entering DONE.
REQ-014 div_sc_mem_rd_done SHALL assert in the CAPTURE of word NUM_WORDS-1; div_sc_mem_wt_done SHALL assert entering DONE.
REQ-015 DONE SHALL hold until enable=0, then return to IDLE; enable changes outside IDLE/DONE SHALL be ignored.
REQ-016 Lane with cdf < cdf_min SHALL yield 0.
REQ-017 Lane with cdf >= cdf_total SHALL yield LEVELS.
REQ-018 If cdf_total <= cdf_min, every lane SHALL yield 0 (no division performed).
REQ-019 Quotient SHALL truncate (floor); never exceed LEVELS.
REQ-020 cdf_min/cdf_total changes after CAPTURE SHALL not affect the current word.

Reset
REQ-021 reset SHALL force IDLE, counter 0, all outputs 0, from any state including mid-DIVIDE; no write issued in that cycle.
REQ-022 reset SHALL dominate enable in the same cycle.

Structure
REQ-023 Shared package hist_eq_pkg SHALL hold FSM state encoding and LEVELS/width derivation functions.
REQ-024 One lane divider sub-module div_lane (Q_W-step restoring divider with clamp logic) SHALL be instantiated LANES times.

Verification
REQ-025 cdf_min=1, cdf_total=0x12C1, all lanes 0x961 -> every lane 127 (0x7F), wt_en pulses NUM_WORDS times.
REQ-026 Lanes {0, 1, 0x12C1, 0xFFFF}, cdf_min=1, cdf_total=0x12C1 -> {0, 0, 255, 255}.
REQ-027 cdf_min=cdf_total=100 -> all lanes 0, timing unchanged.
REQ-028 NUM_WORDS=4 run -> wt_addr 0,1,2,3 at cycles 11,22,33,44 after enable (Q_W=8), wt_done at 44.
REQ-029 reset asserted in DIVIDE of word 2 -> next cycle IDLE, all outputs 0; re-enable restarts at address 0.
REQ-030 enable held high after DONE -> no second run until enable dropped and re-raised.

Source files
------------

// File: rtl/hist_eq_pkg.sv
// hist_eq_pkg: shared definitions for the histogram-equalisation divider.
//   state_e    - sequencer state encoding
//   levels()   - top grey level for a given output width (2^q_w - 1)
//   num_w()    - width of the scaled numerator (cdf - cdf_min) * LEVELS
package hist_eq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_CAPTURE = 3'd2,
    S_DIVIDE  = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  function automatic int levels(input int q_w);
    return (1 << q_w) - 1;
  endfunction

  function automatic int num_w(input int data_w, input int q_w);
    return data_w + q_w;
  endfunction

endpackage

// File: rtl/hist_eq_divider_lane.sv
// div_lane: one lane of the equaliser divider.
// Computes floor((cdf - cdf_min) * LEVELS / (cdf_total - cdf_min)) over Q_W
// cycles, one quotient bit per step, MSB first, with the range clamps applied
// at load time.
//   clk, reset   - clock, synchronous active-high reset
//   load_i       - capture cdf/cdf_min/cdf_total and set up the division
//   step_i       - produce one quotient bit
//   cdf_i        - this lane's CDF value
//   cdf_min_i    - minimum non-zero CDF
//   cdf_total_i  - total pixel count
//   quo_o        - equalised grey level (valid after Q_W steps)
module div_lane
  import hist_eq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int Q_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] cdf_i,
  input  logic [DATA_W-1:0] cdf_min_i,
  input  logic [DATA_W-1:0] cdf_total_i,
  output logic [Q_W-1:0]    quo_o
);

  localparam int             NW   = num_w(DATA_W, Q_W);
  localparam logic [NW-1:0]  LV_N = NW'(levels(Q_W));
  localparam logic [Q_W-1:0] LV_Q = Q_W'(levels(Q_W));

  logic [DATA_W-1:0] diff, den;
  logic [NW-1:0]     num_ld, dsh_ld;
  logic              zero_ld, sat_ld;

  logic [NW-1:0]  rem_q, rem_d;
  logic [NW-1:0]  dsh_q;
  logic [Q_W-1:0] quo_q, quo_d;
  logic           zero_q, sat_q;
  logic           ge;

  assign diff    = cdf_i - cdf_min_i;
  assign den     = cdf_total_i - cdf_min_i;
  assign num_ld  = NW'(diff) * LV_N;
  // Divisor pre-aligned to the first quotient bit; it slides right one place
  // per step, so no variable shifter is needed.
  assign dsh_ld  = NW'(den) << (Q_W - 1);
  // Degenerate range or below-minimum bins map to 0, and that wins over the
  // saturation clamp (covers cdf_total <= cdf_min with cdf >= cdf_total).
  assign zero_ld = (cdf_total_i <= cdf_min_i) || (cdf_i < cdf_min_i);
  assign sat_ld  = (cdf_i >= cdf_total_i);

  // Restoring step: subtract only when the trial result stays non-negative.
  always_comb begin
    ge    = (rem_q >= dsh_q);
    rem_d = ge ? (rem_q - dsh_q) : rem_q;
    quo_d = (quo_q << 1) | Q_W'(ge);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      zero_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (load_i) begin
      rem_q  <= num_ld;
      dsh_q  <= dsh_ld;
      quo_q  <= '0;
      zero_q <= zero_ld;
      sat_q  <= sat_ld;
    end else if (step_i && !zero_q && !sat_q) begin
      rem_q <= rem_d;
      dsh_q <= dsh_q >> 1;
      quo_q <= quo_d;
    end
  end

  // In-range bins have cdf < cdf_total, so the quotient is always < LEVELS.
  assign quo_o = zero_q ? '0 : (sat_q ? LV_Q : quo_q);

endmodule

// File: rtl/hist_eq_divider.sv
// hist_eq_divider: maps a CDF held in scratch memory to equalised grey levels.
// For each of NUM_WORDS words: read the word, capture it, divide all LANES
// lanes in parallel over Q_W cycles, write the results back to the same
// address. Per word: RD_ADDR, CAPTURE, Q_W x DIVIDE, WRITE.
//   clk, reset          - clock, synchronous active-high reset
//   enable              - run request (level; sampled in IDLE and DONE only)
//   cdf_min, cdf_total  - equalisation range, captured per word
//   div_sc_mem_rd_*     - read port (data one cycle after address)
//   div_sc_mem_wt_*     - write port, one strobe per word
//   div_sc_mem_rd_done  - last word read, held until IDLE
//   div_sc_mem_wt_done  - last word written, held until IDLE
//   busy                - run in progress
module hist_eq_divider
  import hist_eq_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int NUM_WORDS = 64,
  parameter int Q_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_W-1:0]       cdf_min,
  input  logic [DATA_W-1:0]       cdf_total,
  output logic [ADDR_W-1:0]       div_sc_mem_rd_addr,
  input  logic [LANES*DATA_W-1:0] div_sc_mem_rd_data,
  output logic [ADDR_W-1:0]       div_sc_mem_wt_addr,
  output logic [LANES*DATA_W-1:0] div_sc_mem_wt_data,
  output logic                    div_sc_mem_wt_en,
  output logic                    div_sc_mem_rd_done,
  output logic                    div_sc_mem_wt_done,
  output logic                    busy
);

  localparam int              STEP_W = $clog2(Q_W + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(Q_W - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                rd_done_q, rd_done_d;
  logic                wt_done_q, wt_done_d;
  logic                last_word;

  logic [LANES-1:0][Q_W-1:0] quo;

  assign last_word = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      step_q    <= '0;
      rd_done_q <= 1'b0;
      wt_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      rd_done_q <= rd_done_d;
      wt_done_q <= wt_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    rd_done_d = rd_done_q;
    wt_done_d = wt_done_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        rd_done_d = 1'b0;
        wt_done_d = 1'b0;
        if (enable) state_d = S_RD_ADDR;
      end
      S_RD_ADDR: state_d = S_CAPTURE;
      S_CAPTURE: begin
        step_d  = '0;
        state_d = S_DIVIDE;
        if (last_word) rd_done_d = 1'b1;
      end
      S_DIVIDE: begin
        step_d = step_q + 1'b1;
        if (step_q == STEP_LAST) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) begin
          state_d   = S_DONE;
          wt_done_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_RD_ADDR;
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_d   = S_IDLE;
          rd_done_d = 1'b0;
          wt_done_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    div_lane #(
      .DATA_W (DATA_W),
      .Q_W    (Q_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .load_i      (state_q == S_CAPTURE),
      .step_i      (state_q == S_DIVIDE),
      .cdf_i       (div_sc_mem_rd_data[i*DATA_W +: DATA_W]),
      .cdf_min_i   (cdf_min),
      .cdf_total_i (cdf_total),
      .quo_o       (quo[i])
    );
    assign div_sc_mem_wt_data[i*DATA_W +: DATA_W] =
      (state_q == S_WRITE) ? DATA_W'(quo[i]) : '0;
  end

  assign busy               = (state_q != S_IDLE) && (state_q != S_DONE);
  assign div_sc_mem_rd_addr = (state_q == S_RD_ADDR) ? cnt_q : '0;
  assign div_sc_mem_wt_addr = (state_q == S_WRITE) ? cnt_q : '0;
  // A reset arriving during WRITE suppresses that word's strobe.
  assign div_sc_mem_wt_en   = (state_q == S_WRITE) && !reset;
  // rd_done rises during the last CAPTURE, then the flag holds it.
  assign div_sc_mem_rd_done = rd_done_q || ((state_q == S_CAPTURE) && last_word);
  assign div_sc_mem_wt_done = wt_done_q;

endmodule

// File: tb/tb_hist_eq_divider.sv
module tb_hist_eq_divider;

  localparam int LANES = 4, DATA_W = 32, ADDR_W = 16, NUM_WORDS = 4, Q_W = 8;
  localparam int DW = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              reset, enable;
  logic [DATA_W-1:0] cdf_min, cdf_total;
  logic [ADDR_W-1:0] rd_addr, wt_addr;
  logic [DW-1:0]     rd_data, wt_data;
  logic              wt_en, rd_done, wt_done, busy;

  hist_eq_divider #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .NUM_WORDS(NUM_WORDS), .Q_W(Q_W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .cdf_min            (cdf_min),
    .cdf_total          (cdf_total),
    .div_sc_mem_rd_addr (rd_addr),
    .div_sc_mem_rd_data (rd_data),
    .div_sc_mem_wt_addr (wt_addr),
    .div_sc_mem_wt_data (wt_data),
    .div_sc_mem_wt_en   (wt_en),
    .div_sc_mem_rd_done (rd_done),
    .div_sc_mem_wt_done (wt_done),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // scratch memory: synchronous read
  logic [DW-1:0] mem [4];
  initial rd_data = '0;
  always @(posedge clk) rd_data <= mem[rd_addr[1:0]];

  // write monitor, edge index relative to the edge that samples enable
  int ecnt = 0, t0 = 0, nw = 0, base = 0;
  int            wr_addr [64];
  logic [DW-1:0] wr_data [64];
  int            wr_edge [64];
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (wt_en && nw < 64) begin
      wr_addr[nw] <= int'(wt_addr);
      wr_data[nw] <= wt_data;
      wr_edge[nw] <= ecnt - t0;
      nw <= nw + 1;
    end
  end

  int total = 0, bad = 0;
  logic [DW-1:0] exp_w [4];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int a, input int b, input int c, input int d);
    return {d[31:0], c[31:0], b[31:0], a[31:0]};
  endfunction

  task automatic start_run(input logic [DATA_W-1:0] mn, input logic [DATA_W-1:0] tot);
    @(negedge clk);
    cdf_min = mn; cdf_total = tot; enable = 1'b1;
    t0 = ecnt; base = nw;
  endtask

  task automatic wait_rel(input int target);
    int e;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      e = ecnt - t0 - 1;
      if (e == target) return;
    end
    chk("wait_timeout", 0, 1);
  endtask

  task automatic finish_run(input bit tchk);
    int e;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      e = ecnt - t0 - 1;
      if (tchk) begin
        if (e == 0)  chk("rd_addr0", rd_addr, 0);
        if (e == 5)  chk("busy_run", busy, 1);
        if (e == 33) begin chk("rd_addr3", rd_addr, 3); chk("rd_done_pre", rd_done, 0); end
        if (e == 34) chk("rd_done_cap", rd_done, 1);
      end
      if (wt_done) begin
        seen = 1'b1;
        chk("done_edge", e, 44);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("n_writes", nw - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wt_addr", wr_addr[base+i], i);
      chk("wt_data", wr_data[base+i], exp_w[i]);
      chk("wt_edge", wr_edge[base+i], 11 * (i + 1));
    end
  endtask

  task automatic end_run();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("idle_wt_done", wt_done, 0);
    chk("idle_rd_done", rd_done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wt_en"}, wt_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wt_addr"}, wt_addr, 0);
    chk({tag, "_wt_data"}, wt_data, 0);
    chk({tag, "_rd_done"}, rd_done, 0);
    chk({tag, "_wt_done"}, wt_done, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cdf_min = '0; cdf_total = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_quiet("rst");
    reset = 1'b0;

    // all lanes mid-range -> 127, plus timing and done behaviour
    for (int i = 0; i < 4; i++) begin
      mem[i] = pk(32'h961, 32'h961, 32'h961, 32'h961);
      exp_w[i] = pk(127, 127, 127, 127);
    end
    start_run(1, 32'h12C1);
    finish_run(1);
    // enable held: no rerun, done flags held
    repeat (30) @(negedge clk);
    chk("no_rerun", nw - base, 4);
    chk("hold_wt_done", wt_done, 1);
    chk("hold_rd_done", rd_done, 1);
    chk("done_busy", busy, 0);
    end_run();

    // clamps and truncation
    mem[0] = pk(0, 1, 32'h12C1, 32'hFFFF);      exp_w[0] = pk(0, 0, 255, 255);
    mem[1] = pk(2, 4800, 1000, 3601);           exp_w[1] = pk(0, 254, 53, 191);
    mem[2] = pk(32'h961, 32'h961, 32'h961, 32'h961); exp_w[2] = pk(127, 127, 127, 127);
    mem[3] = pk(4801, 4800, 32'hFFFFFFFF, 1);   exp_w[3] = pk(255, 254, 255, 0);
    start_run(1, 32'h12C1);
    finish_run(1);
    end_run();

    // degenerate range: cdf_total == cdf_min
    for (int i = 0; i < 4; i++) begin
      mem[i] = pk(50, 100, 150, 32'hFFFF);
      exp_w[i] = '0;
    end
    start_run(100, 100);
    finish_run(1);
    end_run();

    // word 0 keeps its captured range; later words see a degenerate range
    mem[0] = pk(138, 11, 265, 9);  exp_w[0] = pk(127, 0, 254, 0);
    for (int i = 1; i < 4; i++) begin
      mem[i] = pk(32'h961, 32'h961, 32'h961, 32'h961);
      exp_w[i] = '0;
    end
    start_run(10, 266);
    wait_rel(3);
    cdf_min = '0; cdf_total = '0;
    finish_run(0);
    end_run();

    // reset in DIVIDE of word 2, then restart from address 0
    for (int i = 0; i < 4; i++) begin
      mem[i] = pk(32'h961, 32'h961, 32'h961, 32'h961);
      exp_w[i] = pk(127, 127, 127, 127);
    end
    start_run(1, 32'h12C1);
    wait_rel(27);
    chk("busy_mid", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("midrst");
    chk("writes_before_rst", nw - base, 2);
    reset = 1'b0;
    t0 = ecnt; base = nw;
    finish_run(1);
    end_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
